// File: rtl/pc_sequencer_if.sv
// Request/response bundle between the fetch control and the PC sequencer.
// The sequencer itself connects through the slave modport.
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus_step;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_underflow;

  modport master (
    output stall, branch_taken, branch_target,
    output jump, call, ret, jump_target,
    input  pc, pc_plus_step,
    input  ras_empty, ras_full, ras_underflow
  );

  modport slave (
    input  stall, branch_taken, branch_target,
    input  jump, call, ret, jump_target,
    output pc, pc_plus_step,
    output ras_empty, ras_full, ras_underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer with a circular return-address stack.
// One-cycle latency from request to new PC.
module pc_sequencer #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               STEP      = 4,
  parameter int               RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          startin,
  pc_sequencer_if.slave bus
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_RET,
    SEL_UFL,
    SEL_CALL,
    SEL_JUMP,
    SEL_BR,
    SEL_SEQ
  } sel_e;

  sel_e             sel;
  logic [WIDTH-1:0] pc_q, pc_d, step_pc;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d, top;
  logic             ufl_q, ufl_d;
  logic             push;
  logic             empty, full;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  function automatic logic [WIDTH-1:0] align(
    input logic [WIDTH-1:0] a
  );
    return {a[WIDTH-1:2], 2'b00};
  endfunction

  assign step_pc = pc_q + WIDTH'(STEP);
  assign top     = ptr_q - PW'(1);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(RAS_DEPTH));

  always_comb begin
    sel = SEL_SEQ;
    priority case (1'b1)
      bus.stall:        sel = SEL_HOLD;
      bus.ret && !empty: sel = SEL_RET;
      bus.ret:          sel = SEL_UFL;
      bus.call:         sel = SEL_CALL;
      bus.jump:         sel = SEL_JUMP;
      bus.branch_taken: sel = SEL_BR;
      default:          sel = SEL_SEQ;
    endcase
  end

  // ptr_q is the next push slot; when full it also points at the oldest entry
  always_comb begin
    pc_d  = step_pc;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    ufl_d = 1'b0;
    push  = 1'b0;
    unique case (sel)
      SEL_HOLD: pc_d = pc_q;
      SEL_RET: begin
        pc_d  = align(ras_q[top]);
        cnt_d = cnt_q - CW'(1);
        ptr_d = top;
      end
      SEL_UFL: ufl_d = 1'b1;
      SEL_CALL: begin
        pc_d  = align(bus.jump_target);
        push  = 1'b1;
        ptr_d = ptr_q + PW'(1);
        if (!full) cnt_d = cnt_q + CW'(1);
      end
      SEL_JUMP: pc_d = align(bus.jump_target);
      SEL_BR:   pc_d = align(bus.branch_target);
      default:  pc_d = step_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (startin) begin
      pc_q  <= RESET_VEC;
      cnt_q <= '0;
      ptr_q <= '0;
      ufl_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      ufl_q <= ufl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !startin) ras_q[ptr_q] <= step_pc;
  end

  assign bus.pc            = pc_q;
  assign bus.pc_plus_step  = step_pc;
  assign bus.ras_empty     = empty;
  assign bus.ras_full      = full;
  assign bus.ras_underflow = ufl_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_pc_sequencer;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic startin;

  always #5 clk = ~clk;

  pc_sequencer_if #(.WIDTH(32)) bus ();

  pc_sequencer #(
    .WIDTH(32),
    .RESET_VEC(32'h0),
    .STEP(4),
    .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .startin(startin),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic        m_ufl;
  logic [31:0] m_ras [$];

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] al(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

  task automatic model_step();
    logic [31:0] r;
    if (startin) begin
      m_pc  = 32'h0;
      m_ufl = 1'b0;
      m_ras.delete();
    end else if (bus.stall) begin
      m_ufl = 1'b0;
    end else if (bus.ret) begin
      if (m_ras.size() > 0) begin
        r     = m_ras.pop_back();
        m_pc  = al(r);
        m_ufl = 1'b0;
      end else begin
        m_pc  = m_pc + 32'd4;
        m_ufl = 1'b1;
      end
    end else begin
      m_ufl = 1'b0;
      if (bus.call) begin
        if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
        m_ras.push_back(m_pc + 32'd4);
        m_pc = al(bus.jump_target);
      end else if (bus.jump) begin
        m_pc = al(bus.jump_target);
      end else if (bus.branch_taken) begin
        m_pc = al(bus.branch_target);
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic idle();
    startin           = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.jump          = 1'b0;
    bus.call          = 1'b0;
    bus.ret           = 1'b0;
    bus.jump_target   = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("pc", bus.pc, m_pc);
    check("pc_plus", bus.pc_plus_step, m_pc + 32'd4);
    check("empty", 32'(bus.ras_empty), 32'(m_ras.size() == 0));
    check("full", 32'(bus.ras_full), 32'(m_ras.size() == DEPTH));
    check("ufl", 32'(bus.ras_underflow), 32'(m_ufl));
    idle();
  endtask

  task automatic do_reset();
    idle();
    startin = 1'b1;
    cyc();
  endtask

  task automatic do_branch(input logic [31:0] t);
    bus.branch_taken  = 1'b1;
    bus.branch_target = t;
    cyc();
  endtask

  task automatic do_call(input logic [31:0] t);
    bus.call        = 1'b1;
    bus.jump_target = t;
    cyc();
  endtask

  task automatic do_ret();
    bus.ret = 1'b1;
    cyc();
  endtask

  initial begin
    m_pc  = '0;
    m_ufl = 1'b0;
    idle();
    @(negedge clk);

    do_reset();
    check("rst_pc", bus.pc, 32'h0);
    check("rst_empty", 32'(bus.ras_empty), 32'd1);
    check("rst_ufl", 32'(bus.ras_underflow), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check("seq", bus.pc, 32'(i * 4));
    end

    do_reset();
    cyc();
    cyc();
    check("at8", bus.pc, 32'h8);
    bus.jump        = 1'b1;
    bus.jump_target = 32'h103;
    cyc();
    check("jump", bus.pc, 32'h100);
    for (int i = 0; i < 2; i++) begin
      bus.stall = 1'b1;
      bus.ret   = 1'b1;
      bus.call  = 1'b1;
      cyc();
      check("stall", bus.pc, 32'h100);
    end

    do_branch(32'h10);
    do_call(32'h200);
    check("call1", bus.pc, 32'h200);
    cyc();
    do_call(32'h300);
    do_ret();
    check("ret1", bus.pc, 32'h208);
    do_ret();
    check("ret2", bus.pc, 32'h14);
    check("ret_empty", 32'(bus.ras_empty), 32'd1);

    do_branch(32'h1000);
    for (int i = 1; i <= 5; i++) begin
      do_call(32'(32'h1000 * (i + 1)));
      if (i >= 4) check("full_hold", 32'(bus.ras_full), 32'd1);
    end
    for (int i = 5; i >= 2; i--) begin
      do_ret();
      check("wrap_ret", bus.pc, 32'(32'h1000 * i + 4));
    end
    check("wrap_empty", 32'(bus.ras_empty), 32'd1);

    do_branch(32'h40);
    do_ret();
    check("ufl_pc", bus.pc, 32'h44);
    check("ufl_on", 32'(bus.ras_underflow), 32'd1);
    cyc();
    check("ufl_off", 32'(bus.ras_underflow), 32'd0);
    do_branch(32'h6C);
    do_call(32'h50);
    bus.call        = 1'b1;
    bus.jump_target = 32'h900;
    do_ret();
    check("callret_pc", bus.pc, 32'h70);
    check("callret_empty", 32'(bus.ras_empty), 32'd1);

    do_branch(32'hFFFF_FFFC);
    cyc();
    check("wrap_pc", bus.pc, 32'h0);
    do_branch(32'h500);
    startin = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h800;
    cyc();
    check("rst_br", bus.pc, 32'h0);

    do_call(32'h600);
    do_call(32'h700);
    startin  = 1'b1;
    bus.ret  = 1'b1;
    cyc();
    do_ret();
    check("stale_ufl", 32'(bus.ras_underflow), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      startin           = ($urandom_range(0, 99) == 0);
      bus.stall         = ($urandom_range(0, 4) == 0);
      bus.ret           = ($urandom_range(0, 3) == 0);
      bus.call          = ($urandom_range(0, 2) == 0);
      bus.jump          = ($urandom_range(0, 5) == 0);
      bus.branch_taken  = ($urandom_range(0, 3) == 0);
      bus.branch_target = $urandom;
      bus.jump_target   = $urandom;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the PC and target width in bits.
REQ-002 Parameter RESET_VEC, default 0, SHALL set the PC value loaded on reset.
REQ-003 Parameter STEP, default 4, SHALL set the sequential increment.
REQ-004 Parameter RAS_DEPTH, default 4 (a power of 2, at least 2), SHALL set the return-address-stack entry count.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 startin  in  1  SHALL be the reset, synchronous and active-high.
REQ-007 stall  in  1  SHALL freeze PC and RAS when high.
REQ-008 branch_taken  in  1  SHALL request a load of branch_target.
REQ-009 branch_target  in  WIDTH  SHALL be the absolute branch destination.
REQ-010 jump  in  1  SHALL request a load of jump_target.
REQ-011 call  in  1  SHALL request a load of jump_target plus a push of pc+STEP.
REQ-012 ret  in  1  SHALL request a pop, with PC loaded from the popped entry.
REQ-013 jump_target  in  WIDTH  SHALL be the jump and call destination.
REQ-014 pc  out  WIDTH  SHALL be the registered current PC.
REQ-015 pc_plus_step  out  WIDTH  SHALL be the combinational pc+STEP, modulo 2^WIDTH.
REQ-016 ras_empty  out  1  SHALL be high when the RAS count is 0.
REQ-017 ras_full  out  1  SHALL be high when the RAS count equals RAS_DEPTH.
REQ-018 ras_underflow  out  1  SHALL be a registered one-cycle pulse flagging ret on an empty RAS.

Function
REQ-019 Next-PC priority SHALL be startin > stall > ret > call > jump > branch_taken > sequential.
REQ-020 Sequential advance SHALL load pc+STEP, wrapping modulo 2^WIDTH (0xFFFFFFFC -> 0x0 at defaults).
REQ-021 Any loaded target (branch, jump, call, ret) SHALL have bits [1:0] forced to 0.
REQ-022 Latency SHALL be one cycle: a request sampled at edge N yields the new pc after edge N.
REQ-023 While stall=1, pc, RAS contents, RAS count and ras_underflow (driven 0) SHALL hold; all requests are ignored, not queued.
REQ-024 A winning call SHALL push pc+STEP (the current pc_plus_step) and increment the count.
REQ-025 A call with ras_full=1 SHALL overwrite the oldest entry (circular), keep the count at RAS_DEPTH, and keep ras_full=1.
REQ-026 A winning ret with count>0 SHALL load the most recent entry into pc and decrement the count.
REQ-027 A winning ret with count=0 SHALL advance pc by STEP, leave the RAS unchanged, and assert ras_underflow for exactly the next cycle.
REQ-028 Simultaneous call and ret SHALL resolve as ret only: pop, no push.
REQ-029 Requests losing on priority SHALL have no effect on the RAS.
REQ-030 ras_empty and ras_full SHALL be derived combinationally from the registered count.

Reset
REQ-031 startin=1 at a rising edge SHALL set pc=RESET_VEC, RAS count=0 and ras_underflow=0, overriding stall and all requests.
REQ-032 Reset mid-call or mid-ret SHALL discard that operation; stale RAS entries need not be cleared but SHALL be unreachable.
REQ-033 Before the first reset, outputs are undefined; the bench SHALL NOT check them.

Verification
REQ-034 Reset then 3 idle cycles -> pc sequence 0x0, 0x4, 0x8, 0xC; ras_empty=1.
REQ-035 At pc=0x8, jump=1 with jump_target=0x103 -> pc=0x100 next cycle; then stall=1 for 2 cycles -> pc stays 0x100.
REQ-036 At pc=0x10, call to 0x200, then at 0x204 call to 0x300, then ret twice -> pc=0x208, then 0x14; ras_empty=1 after.
REQ-037 Five calls with RAS_DEPTH=4, then four rets -> returns of calls 5, 4, 3 and 2 in order; ras_full stays 1 after call 5; the first entry is lost.
REQ-038 ret on an empty RAS at pc=0x40 -> pc=0x44, ras_underflow=1 for one cycle; call and ret together at pc=0x50 with one entry 0x70 -> pc=0x70, count 0.
REQ-039 pc=0xFFFFFFFC idle -> pc=0x0; startin asserted together with branch_taken -> pc=RESET_VEC.
